// File: rtl/tx_intf.sv
// Shared transmit-status definitions: controller state encoding and the
// tx_status field layout, also used by the downstream status FIFO packer.
package tx_intf;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX       = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RETRY    = 2'd3
  } tx_state_e;

  localparam int STATUS_W  = 5;
  localparam int FAIL_BIT  = 4;
  localparam int RETRY_MSB = 3;
  localparam int RETRY_LSB = 0;
  localparam int RETRY_W   = RETRY_MSB - RETRY_LSB + 1;

  function automatic logic [STATUS_W-1:0] pack_status(input logic fail,
                                                      input logic [RETRY_W-1:0] retry_cnt);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[FAIL_BIT] = fail;
    s[RETRY_MSB:RETRY_LSB] = retry_cnt;
    return s;
  endfunction

endpackage

// File: rtl/ack_timeout_cnt.sv
// ACK wait timer: cleared by load, counts up while enabled, expire when the
// count equals the programmed window (so a window of 0 expires immediately).
module ack_timeout_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] top,
  output logic         expire
);

  logic [W-1:0] count;

  // Saturate rather than wrap if the window is reprogrammed below the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                count <= '0;
    else if (load)                            count <= '0;
    else if (enable && (count != {W{1'b1}}))  count <= count + 1'b1;
  end

  assign expire = (count == top);

endmodule

// File: rtl/tx_status_gen.sv
// Per-packet transmit controller: tracks attempts, ACK timeouts and retries,
// and reports one registered completion status per packet.
//
// state       | meaning
// ST_IDLE     | no packet open, waiting for first-attempt tx_start
// ST_TX       | PHY attempt on air, waiting for tx_end
// ST_WAIT_ACK | attempt done, ACK window running
// ST_RETRY    | retransmission requested, waiting for tx_start
module tx_status_gen
  import tx_intf::*;
#(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            tx_start,
  input  logic [1:0]      pkt_prio,
  input  logic [9:0]      pkt_sn,
  input  logic            ack_required,
  input  logic            tx_end,
  input  logic            ack_ok,
  input  logic [3:0]      max_retry,
  input  logic [TO_W-1:0] ack_timeout_top,
  output logic            retrans_req,
  output logic            tx_try_complete,
  output logic [4:0]      tx_status,
  output logic [1:0]      linux_prio,
  output logic [9:0]      tx_pkt_sn,
  output logic            proto_err
);

  tx_state_e state, state_nxt;

  logic [1:0] prio_q;
  logic [9:0] sn_q;
  logic       ack_req_q;
  logic [3:0] retry_cnt;

  logic to_load, to_en, to_expire;
  logic latch_pkt, done_nxt, fail_nxt, retrans_nxt, err_nxt;
  logic retry_avail;

  assign retry_avail = (retry_cnt < max_retry);

  ack_timeout_cnt #(.W(TO_W)) u_ack_timeout_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .load   (to_load),
    .enable (to_en),
    .top    (ack_timeout_top),
    .expire (to_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ack_ok wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (tx_start) state_nxt = ST_TX;
      ST_TX:       if (tx_end) state_nxt = ack_req_q ? ST_WAIT_ACK : ST_IDLE;
      ST_WAIT_ACK: begin
        if (ack_ok)         state_nxt = ST_IDLE;
        else if (to_expire) state_nxt = retry_avail ? ST_RETRY : ST_IDLE;
      end
      ST_RETRY:    if (tx_start) state_nxt = ST_TX;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_pkt   = (state == ST_IDLE) && tx_start;
    to_load     = (state == ST_TX) && tx_end && ack_req_q;
    to_en       = (state == ST_WAIT_ACK);
    retrans_nxt = (state == ST_WAIT_ACK) && !ack_ok && to_expire && retry_avail;
    fail_nxt    = (state == ST_WAIT_ACK) && !ack_ok && to_expire && !retry_avail;
    done_nxt    = ((state == ST_TX) && tx_end && !ack_req_q) ||
                  ((state == ST_WAIT_ACK) && ack_ok) || fail_nxt;
    err_nxt     = (tx_start && (state != ST_IDLE) && (state != ST_RETRY)) ||
                  (tx_end && (state != ST_TX)) ||
                  (ack_ok && (state != ST_WAIT_ACK));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q    <= '0;
      sn_q      <= '0;
      ack_req_q <= 1'b0;
      retry_cnt <= '0;
    end else if (latch_pkt) begin
      prio_q    <= pkt_prio;
      sn_q      <= pkt_sn;
      ack_req_q <= ack_required;
      retry_cnt <= '0;
    end else if (retrans_nxt) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retrans_req     <= 1'b0;
      tx_try_complete <= 1'b0;
      tx_status       <= '0;
      linux_prio      <= '0;
      tx_pkt_sn       <= '0;
      proto_err       <= 1'b0;
    end else begin
      retrans_req     <= retrans_nxt;
      tx_try_complete <= done_nxt;
      proto_err       <= proto_err | err_nxt;
      if (done_nxt) begin
        tx_status  <= pack_status(fail_nxt, retry_cnt);
        linux_prio <= prio_q;
        tx_pkt_sn  <= sn_q;
      end
    end
  end

endmodule

// File: tb/tb_tx_status_gen.sv
// Bench for tx_status_gen: packet-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tx_status_gen;

  localparam int TO_W = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            tx_start = 1'b0;
  logic [1:0]      pkt_prio = '0;
  logic [9:0]      pkt_sn = '0;
  logic            ack_required = 1'b0;
  logic            tx_end = 1'b0;
  logic            ack_ok = 1'b0;
  logic [3:0]      max_retry = '0;
  logic [TO_W-1:0] ack_timeout_top = '0;
  logic            retrans_req, tx_try_complete, proto_err;
  logic [4:0]      tx_status;
  logic [1:0]      linux_prio;
  logic [9:0]      tx_pkt_sn;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_retx = 0;

  // reference model state (packet-level view)
  bit         pkt_open = 0, on_air = 0, waiting = 0, cur_ack = 0;
  int         wait_cyc = 0, retries = 0;
  logic [1:0] cur_prio = '0;
  logic [9:0] cur_sn = '0;
  logic       e_retx = 0, e_done = 0, e_err = 0;
  logic [4:0] e_status = '0;
  logic [1:0] e_prio = '0;
  logic [9:0] e_sn = '0;

  tx_status_gen #(.TO_W(TO_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .tx_start        (tx_start),
    .pkt_prio        (pkt_prio),
    .pkt_sn          (pkt_sn),
    .ack_required    (ack_required),
    .tx_end          (tx_end),
    .ack_ok          (ack_ok),
    .max_retry       (max_retry),
    .ack_timeout_top (ack_timeout_top),
    .retrans_req     (retrans_req),
    .tx_try_complete (tx_try_complete),
    .tx_status       (tx_status),
    .linux_prio      (linux_prio),
    .tx_pkt_sn       (tx_pkt_sn),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_pkt(input bit fail);
    e_done   = 1;
    e_status = {fail, 4'(retries)};
    e_prio   = cur_prio;
    e_sn     = cur_sn;
    pkt_open = 0;
    on_air   = 0;
    waiting  = 0;
  endtask

  // Model: what the outputs must be after each clock edge.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        pkt_open = 0; on_air = 0; waiting = 0; cur_ack = 0;
        wait_cyc = 0; retries = 0; cur_prio = '0; cur_sn = '0;
        e_retx = 0; e_done = 0; e_err = 0; e_status = '0; e_prio = '0; e_sn = '0;
      end else begin
        e_retx = 0;
        e_done = 0;
        if (tx_start && (on_air || waiting)) e_err = 1;
        if (tx_end && !on_air)               e_err = 1;
        if (ack_ok && !waiting)              e_err = 1;
        if (!pkt_open && tx_start) begin
          pkt_open = 1; on_air = 1; retries = 0;
          cur_prio = pkt_prio; cur_sn = pkt_sn; cur_ack = ack_required;
        end else if (pkt_open && !on_air && !waiting && tx_start) begin
          on_air = 1;
        end else if (on_air && tx_end) begin
          on_air = 0;
          if (cur_ack) begin
            waiting  = 1;
            wait_cyc = 0;
          end else begin
            finish_pkt(0);
          end
        end else if (waiting) begin
          if (ack_ok) finish_pkt(0);
          else if (wait_cyc == int'(ack_timeout_top)) begin
            if (retries < int'(max_retry)) begin
              retries++;
              e_retx  = 1;
              waiting = 0;
            end else begin
              finish_pkt(1);
            end
          end else begin
            wait_cyc++;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("retrans_req", retrans_req, e_retx);
      chk("tx_try_complete", tx_try_complete, e_done);
      chk("tx_status", tx_status, e_status);
      chk("linux_prio", linux_prio, e_prio);
      chk("tx_pkt_sn", tx_pkt_sn, e_sn);
      chk("proto_err", proto_err, e_err);
      if (tx_try_complete === 1'b1) n_done++;
      if (retrans_req === 1'b1) n_retx++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want test end");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] p, input logic [9:0] s, input logic a);
    pkt_prio = p; pkt_sn = s; ack_required = a; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic pulse_end();
    tx_end = 1'b1;
    tick(1);
    tx_end = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_ok = 1'b1;
    tick(1);
    ack_ok = 1'b0;
  endtask

  int d0, r0;

  initial begin
    #2;
    chk("rst_status", tx_status, 5'h00);
    chk("rst_done", tx_try_complete, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick(1);

    // no-ACK packet
    max_retry = 4'd0; ack_timeout_top = 16'd10;
    d0 = n_done; r0 = n_retx;
    pulse_start(2'd2, 10'h155, 1'b0);
    tick(2); pulse_end(); tick(3);
    chk("noack_done", n_done - d0, 1);
    chk("noack_status", tx_status, 5'h00);
    chk("noack_prio", linux_prio, 2'd2);
    chk("noack_sn", tx_pkt_sn, 10'h155);

    // ACK 40 cycles after tx_end, window 100
    max_retry = 4'd7; ack_timeout_top = 16'd100;
    d0 = n_done; r0 = n_retx;
    pulse_start(2'd1, 10'h0a3, 1'b1);
    tick(3); pulse_end(); tick(39); pulse_ack(); tick(3);
    chk("ack1_done", n_done - d0, 1);
    chk("ack1_retx", n_retx - r0, 0);
    chk("ack1_status", tx_status, 5'h00);

    // two timeouts then ACK; retransmit starts carry junk fields
    ack_timeout_top = 16'd10;
    d0 = n_done; r0 = n_retx;
    pulse_start(2'd3, 10'h2c4, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(2); pulse_end(); tick(13);
      pulse_start(2'd0, 10'h001, 1'b0);
    end
    tick(2); pulse_end(); tick(4); pulse_ack(); tick(3);
    chk("ack3_retx", n_retx - r0, 2);
    chk("ack3_done", n_done - d0, 1);
    chk("ack3_status", tx_status, 5'h02);
    chk("ack3_prio", linux_prio, 2'd3);
    chk("ack3_sn", tx_pkt_sn, 10'h2c4);

    // give up after 3 retries
    max_retry = 4'd3; ack_timeout_top = 16'd6;
    d0 = n_done; r0 = n_retx;
    pulse_start(2'd1, 10'h19a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(2); pulse_end(); tick(9);
      pulse_start(2'd2, 10'h000, 1'b0);
    end
    tick(2); pulse_end(); tick(10);
    chk("giveup3_retx", n_retx - r0, 3);
    chk("giveup3_done", n_done - d0, 1);
    chk("giveup3_status", tx_status, 5'h13);

    // single attempt with max_retry=0
    max_retry = 4'd0;
    d0 = n_done; r0 = n_retx;
    pulse_start(2'd0, 10'h3ff, 1'b1);
    tick(2); pulse_end(); tick(10);
    chk("giveup0_retx", n_retx - r0, 0);
    chk("giveup0_status", tx_status, 5'h10);
    chk("giveup0_sn", tx_pkt_sn, 10'h3ff);

    // zero window: expires in the first wait cycle, result one cycle later
    max_retry = 4'd1; ack_timeout_top = 16'd0;
    pulse_start(2'd1, 10'h0f0, 1'b1);
    tick(1); pulse_end(); tick(1);
    chk("top0_retrans_pulse", retrans_req, 1'b1);
    pulse_start(2'd3, 10'h005, 1'b0);
    pulse_end(); tick(1);
    chk("top0_done_pulse", tx_try_complete, 1'b1);
    chk("top0_status", tx_status, 5'h11);
    tick(2);

    // ACK coincident with timeout resolves as success
    max_retry = 4'd2; ack_timeout_top = 16'd5;
    d0 = n_done; r0 = n_retx;
    pulse_start(2'd3, 10'h2aa, 1'b1);
    tick(2); pulse_end(); tick(5); pulse_ack(); tick(3);
    chk("coinc_done", n_done - d0, 1);
    chk("coinc_retx", n_retx - r0, 0);
    chk("coinc_status", tx_status, 5'h00);

    // stray tx_end while idle
    chk("stray_pre_err", proto_err, 1'b0);
    d0 = n_done;
    pulse_end(); tick(2);
    chk("stray_err", proto_err, 1'b1);
    chk("stray_done", n_done - d0, 0);
    pulse_ack(); tick(2);
    chk("stray_err_sticky", proto_err, 1'b1);

    // reset while waiting for ACK
    ack_timeout_top = 16'd50;
    pulse_start(2'd2, 10'h111, 1'b1);
    tick(2); pulse_end(); tick(5);
    rstn = 1'b0;
    #1;
    chk("rst_mid_err", proto_err, 1'b0);
    chk("rst_mid_prio", linux_prio, 2'd0);
    chk("rst_mid_sn", tx_pkt_sn, 10'h000);
    chk("rst_mid_status", tx_status, 5'h00);
    chk("rst_mid_retx", retrans_req, 1'b0);
    tick(2);
    rstn = 1'b1;
    d0 = n_done; r0 = n_retx;
    tick(60);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_no_retx", n_retx - r0, 0);
    pulse_start(2'd1, 10'h222, 1'b0);
    tick(2); pulse_end(); tick(3);
    chk("post_rst_done", n_done - d0, 1);
    chk("post_rst_status", tx_status, 5'h00);
    chk("post_rst_prio", linux_prio, 2'd1);
    chk("post_rst_sn", tx_pkt_sn, 10'h222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
